// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak sponge controller: FSM states, rate helper
// and the SHA-3 padding bytes.
package keccak_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ABSORB,
        PERMUTE,
        PAD,
        FINAL_PERM,
        DONE
    } sponge_state_t;

    // SHA-3 domain separator (first pad byte) and closing pad bit (last rate byte)
    localparam logic [7:0] PAD_DOMAIN = 8'h06;
    localparam logic [7:0] PAD_FINAL  = 8'h80;

    // Rate in 32-bit words: capacity is twice the digest size
    function automatic int rate_words(input int sha3_size);
        return (200 - sha3_size / 4) / 4;
    endfunction

endpackage

// File: rtl/keccak_sponge_ctrl.sv
// Sponge controller: streams 32-bit message words into the Keccak state as
// XOR writes, applies SHA-3 padding and sequences the permutations.
module keccak_sponge_ctrl
    import keccak_pkg::*;
#(
    parameter int C_SHA3_SIZE = 224
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [1:0]  in_bytes,
    output logic        absorb_we,
    output logic [5:0]  absorb_idx,
    output logic [31:0] absorb_data,
    output logic        state_clear,
    output logic        perm_start,
    input  logic        perm_done,
    output logic        hash_valid
);

    localparam int         RW       = rate_words(C_SHA3_SIZE);
    localparam logic [5:0] LAST_IDX = 6'(RW - 1);

    sponge_state_t r_state, w_state_next;
    logic [5:0]    r_idx, w_idx_next;
    logic          r_started, w_started_next;
    logic          r_in_ready, w_in_ready_next;
    logic          r_absorb_we, w_absorb_we_next;
    logic [5:0]    r_absorb_idx, w_absorb_idx_next;
    logic [31:0]   r_absorb_data, w_absorb_data_next;
    logic          r_state_clear, w_state_clear_next;
    logic          r_perm_start, w_perm_start_next;
    logic          r_hash_valid, w_hash_valid_next;

    logic          w_hs;
    logic [31:0]   w_word_data;

    // Byte j of the message word lands in lane bits [8j+7:8j]; on the last
    // word the domain byte follows the valid bytes and the rest is zero.
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        localparam logic [1:0] BI = 2'(gi);
        logic [7:0] w_msg_byte;
        assign w_msg_byte = in_data[31 - 8 * gi -: 8];
        assign w_word_data[8 * gi +: 8] = (!in_last || (BI < in_bytes)) ? w_msg_byte :
                                          (BI == in_bytes)              ? PAD_DOMAIN :
                                                                          8'h00;
    end

    assign w_hs = in_valid & r_in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_started     <= 1'b0;
            r_in_ready    <= 1'b0;
            r_absorb_we   <= 1'b0;
            r_absorb_idx  <= '0;
            r_absorb_data <= '0;
            r_state_clear <= 1'b0;
            r_perm_start  <= 1'b0;
            r_hash_valid  <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_idx         <= w_idx_next;
            r_started     <= w_started_next;
            r_in_ready    <= w_in_ready_next;
            r_absorb_we   <= w_absorb_we_next;
            r_absorb_idx  <= w_absorb_idx_next;
            r_absorb_data <= w_absorb_data_next;
            r_state_clear <= w_state_clear_next;
            r_perm_start  <= w_perm_start_next;
            r_hash_valid  <= w_hash_valid_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_idx_next         = r_idx;
        w_started_next     = r_started;
        w_absorb_we_next   = 1'b0;
        w_absorb_idx_next  = r_absorb_idx;
        w_absorb_data_next = r_absorb_data;
        w_state_clear_next = 1'b0;
        w_perm_start_next  = 1'b0;
        w_hash_valid_next  = r_hash_valid;

        if (cmd_start) begin
            w_state_next       = ABSORB;
            w_idx_next         = '0;
            w_started_next     = 1'b0;
            w_state_clear_next = 1'b1;
            w_hash_valid_next  = 1'b0;
        end else begin
            case (r_state)
                ABSORB: begin
                    if (w_hs) begin
                        w_absorb_we_next   = 1'b1;
                        w_absorb_idx_next  = r_idx;
                        w_absorb_data_next = w_word_data;
                        w_started_next     = 1'b0;
                        if (in_last) begin
                            w_state_next = PAD;
                        end else if (r_idx == LAST_IDX) begin
                            w_state_next = PERMUTE;
                        end else begin
                            w_idx_next = r_idx + 6'd1;
                        end
                    end
                end
                // perm_start waits one cycle after entry so it never
                // coincides with the block's final absorb write
                PERMUTE, FINAL_PERM: begin
                    if (!r_started) begin
                        w_perm_start_next = 1'b1;
                        w_started_next    = 1'b1;
                    end else if (perm_done && !r_perm_start) begin
                        w_started_next = 1'b0;
                        w_idx_next     = '0;
                        if (r_state == FINAL_PERM) begin
                            w_state_next      = DONE;
                            w_hash_valid_next = 1'b1;
                        end else begin
                            w_state_next = ABSORB;
                        end
                    end
                end
                PAD: begin
                    w_absorb_we_next   = 1'b1;
                    w_absorb_idx_next  = LAST_IDX;
                    w_absorb_data_next = {PAD_FINAL, 24'h000000};
                    w_started_next     = 1'b0;
                    w_state_next       = FINAL_PERM;
                end
                default: ;
            endcase
        end

        w_in_ready_next = (w_state_next == ABSORB);
    end

    assign in_ready    = r_in_ready;
    assign absorb_we   = r_absorb_we;
    assign absorb_idx  = r_absorb_idx;
    assign absorb_data = r_absorb_data;
    assign state_clear = r_state_clear;
    assign perm_start  = r_perm_start;
    assign hash_valid  = r_hash_valid;

endmodule

// File: tb/tb_keccak_sponge_ctrl.sv
// Directed bench for keccak_sponge_ctrl (SHA3-224, 36-word rate); expected
// absorb writes are queued at stimulus time and checked by a monitor.
module tb_keccak_sponge_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [1:0]  in_bytes = '0;
    logic        absorb_we;
    logic [5:0]  absorb_idx;
    logic [31:0] absorb_data;
    logic        state_clear;
    logic        perm_start;
    logic        perm_done = 1'b0;
    logic        hash_valid;

    int          n_asserts = 0;
    int          n_fails = 0;
    int          perm_cnt = 0;
    logic [37:0] sb_q[$];

    keccak_sponge_ctrl #(.C_SHA3_SIZE(224)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_start   (cmd_start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_bytes    (in_bytes),
        .absorb_we   (absorb_we),
        .absorb_idx  (absorb_idx),
        .absorb_data (absorb_data),
        .state_clear (state_clear),
        .perm_start  (perm_start),
        .perm_done   (perm_done),
        .hash_valid  (hash_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every absorb write must match the head of the scoreboard
    always @(negedge clk) begin
        logic [37:0] exp_w;
        if (perm_start) perm_cnt++;
        if (absorb_we || perm_start) begin
            n_asserts++;
            assert (!(absorb_we && perm_start)) else begin
                n_fails++;
                $error("FAIL we_perm_overlap: observed we=%0b ps=%0b expected not both", absorb_we, perm_start);
            end
        end
        if (absorb_we) begin
            n_asserts++;
            if (sb_q.size() == 0) begin
                assert (1'b0) else begin
                    n_fails++;
                    $error("FAIL unexpected_write: observed idx=%0d data=%08h expected no write", absorb_idx, absorb_data);
                end
            end else begin
                exp_w = sb_q.pop_front();
                assert ({absorb_idx, absorb_data} === exp_w) else begin
                    n_fails++;
                    $error("FAIL absorb_write: observed idx=%0d data=%08h expected idx=%0d data=%08h",
                           absorb_idx, absorb_data, exp_w[37:32], exp_w[31:0]);
                end
            end
            $display("write idx=%0d data=%08h", absorb_idx, absorb_data);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_hash();
        tick();
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        check("start_clear", 64'(state_clear), 64'd1);
        check("start_ready", 64'(in_ready), 64'd1);
        check("start_hv", 64'(hash_valid), 64'd0);
    endtask

    task automatic send(input logic [31:0] d, input logic last, input logic [1:0] nb,
                        input logic [5:0] exp_idx, input logic [31:0] exp_data);
        int guard = 0;
        tick();
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        check("send_ready", 64'(in_ready), 64'd1);
        sb_q.push_back({exp_idx, exp_data});
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bytes = '0;
    endtask

    // Word i carries bytes 4i..4i+3 in arrival order
    task automatic send_block(input int count);
        for (int i = 0; i < count; i++) begin
            send({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}, 1'b0, 2'd0,
                 6'(i), {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
        end
    endtask

    task automatic wait_perm(input int base);
        int guard = 0;
        while (perm_cnt <= base && guard < 200) begin
            tick();
            guard++;
        end
        check("perm_seen", 64'(perm_cnt > base), 64'd1);
    endtask

    task automatic pulse_done();
        tick();
        perm_done = 1'b1;
        tick();
        perm_done = 1'b0;
    endtask

    initial begin
        int base;

        // Reset values
        #2;
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_we", 64'(absorb_we), 64'd0);
        check("rst_idx", 64'(absorb_idx), 64'd0);
        check("rst_data", 64'(absorb_data), 64'd0);
        check("rst_clear", 64'(state_clear), 64'd0);
        check("rst_ps", 64'(perm_start), 64'd0);
        check("rst_hv", 64'(hash_valid), 64'd0);
        tick();
        tick();
        reset = 1'b0;

        // Empty message: pad only
        start_hash();
        base = perm_cnt;
        send(32'h0, 1'b1, 2'd0, 6'd0, 32'h00000006);
        check("a_ready_drop", 64'(in_ready), 64'd0);
        sb_q.push_back({6'd35, 32'h80000000});
        wait_perm(base);
        pulse_done();
        check("a_hv", 64'(hash_valid), 64'd1);
        check("a_perm_cnt", 64'(perm_cnt - base), 64'd1);
        $display("test A empty message done");

        // "Hell" + "o" with one valid byte in the last word
        start_hash();
        base = perm_cnt;
        send(32'h48656C6C, 1'b0, 2'd0, 6'd0, 32'h6C6C6548);
        send(32'h6F202020, 1'b1, 2'd1, 6'd1, 32'h0000066F);
        sb_q.push_back({6'd35, 32'h80000000});
        wait_perm(base);
        pulse_done();
        check("b_hv", 64'(hash_valid), 64'd1);
        $display("test B hello done");

        // Full block: permutation, then absorb restarts at index 0
        start_hash();
        check("c_hv_cleared", 64'(hash_valid), 64'd0);
        base = perm_cnt;
        send_block(36);
        check("c_ready_drop", 64'(in_ready), 64'd0);
        wait_perm(base);
        repeat (5) tick();
        check("c_ready_hold", 64'(in_ready), 64'd0);
        check("c_perm_once", 64'(perm_cnt - base), 64'd1);
        pulse_done();
        check("c_ready_back", 64'(in_ready), 64'd1);
        send(32'hDEADBEEF, 1'b0, 2'd0, 6'd0, 32'hEFBEADDE);
        $display("test C full block done");

        // Last word lands in word 35 with 3 bytes
        start_hash();
        base = perm_cnt;
        send_block(35);
        send(32'h61626320, 1'b1, 2'd3, 6'd35, 32'h06636261);
        sb_q.push_back({6'd35, 32'h80000000});
        wait_perm(base);
        check("d_perm_once", 64'(perm_cnt - base), 64'd1);
        pulse_done();
        check("d_hv", 64'(hash_valid), 64'd1);
        $display("test D pad in last word done");

        // Restart during PERMUTE, then a stray perm_done
        start_hash();
        base = perm_cnt;
        send_block(36);
        wait_perm(base);
        start_hash();
        base = perm_cnt;
        pulse_done();
        check("e_ready", 64'(in_ready), 64'd1);
        check("e_hv", 64'(hash_valid), 64'd0);
        repeat (3) tick();
        check("e_no_perm", 64'(perm_cnt - base), 64'd0);
        send(32'hA1B2C3D4, 1'b0, 2'd0, 6'd0, 32'hD4C3B2A1);
        $display("test E restart during permute done");

        // Asynchronous reset mid-absorb
        start_hash();
        base = perm_cnt;
        send_block(3);
        #2;
        reset = 1'b1;
        #1;
        check("f_rst_ready", 64'(in_ready), 64'd0);
        check("f_rst_idx", 64'(absorb_idx), 64'd0);
        check("f_rst_data", 64'(absorb_data), 64'd0);
        check("f_rst_we", 64'(absorb_we), 64'd0);
        check("f_rst_clear", 64'(state_clear), 64'd0);
        check("f_rst_hv", 64'(hash_valid), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("f_idle_ready", 64'(in_ready), 64'd0);
        start_hash();
        send(32'h11223344, 1'b0, 2'd2, 6'd0, 32'h44332211);
        repeat (3) tick();
        check("f_no_perm", 64'(perm_cnt - base), 64'd0);
        check("f_sb_empty", 64'(sb_q.size()), 64'd0);
        $display("test F reset mid-absorb done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
